// File: rtl/uart_rx_sync.sv
// 8N1 serial receiver: two-flop RX synchroniser, mid-bit sampling, sticky ready/error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_sync #(
  parameter int BAUD_DIV  = 2604,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] FULL_BIT = BW'(BAUD_DIV);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

  state_t state, next_state;

  logic                 rx_meta, rx_s, rx_s_prev;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 start_det, baud_done;
  logic                 load_half, counting, shift_en, good_stop, bad_stop, commit;

  assign start_det = rx_s_prev & ~rx_s;
  // The expiry edge is the one that takes the down-counter to zero; it samples and reloads.
  assign baud_done = (baud_cnt <= BW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_det) next_state = START;
      START:   if (baud_done) next_state = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:    if (baud_done && bit_cnt == LAST_BIT) next_state = PARITY;
      PARITY:  if (baud_done) next_state = STOP;
`else
      DATA:    if (baud_done && bit_cnt == LAST_BIT) next_state = STOP;
`endif
      STOP:    if (baud_done) next_state = rx_s ? IDLE : WAIT_HI;
      WAIT_HI: if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_half = (state == IDLE) && start_det;
    counting  = (state == START) || (state == DATA) || (state == STOP);
`ifdef UART_RX_PARITY_EN
    counting  = counting || (state == PARITY);
`endif
    shift_en  = (state == DATA) && baud_done;
    good_stop = (state == STOP) && baud_done && rx_s;
    bad_stop  = (state == STOP) && baud_done && !rx_s;
  end

`ifdef UART_RX_PARITY_EN
  logic par_sample, par_bad;
  assign par_sample = (state == PARITY) && baud_done;
  assign commit     = good_stop && !par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (load_half)       par_bad <= 1'b0;
      else if (par_sample) par_bad <= ^{shift, rx_s};
      if (par_sample && (^{shift, rx_s})) parity_err <= 1'b1;
      else if (clr_rdy)                   parity_err <= 1'b0;
    end
  end
`else
  assign commit     = good_stop;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_s_prev   <= 1'b1;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rdy         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_meta   <= RX;
      rx_s      <= rx_meta;
      rx_s_prev <= rx_s;

      if (load_half)                 baud_cnt <= HALF_BIT;
      else if (counting && baud_done) baud_cnt <= FULL_BIT;
      else if (counting)             baud_cnt <= baud_cnt - BW'(1);

      if (state == START)  bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + CW'(1);

      // LSB arrives first, so each new bit enters at the top and ripples down.
      if (shift_en) shift <= {rx_s, shift[DATA_BITS-1:1]};

      if (commit) rx_data <= shift;

      if (commit)       rdy <= 1'b1;
      else if (clr_rdy) rdy <= 1'b0;

      if (commit && rdy && !clr_rdy) overrun <= 1'b1;
      else if (clr_rdy)              overrun <= 1'b0;

      if (bad_stop)     framing_err <= 1'b1;
      else if (clr_rdy) framing_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_sync.sv
// Randomised bench for uart_rx_sync: frame-level reference model plus a scoreboard monitor on rdy.
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_sync;

  localparam int BD = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + BD/2 + (DB+2)*BD + 1;
`else
  localparam int LAT = 2 + BD/2 + (DB+1)*BD + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX = 1'b1;
  logic          clr_rdy = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rdy, framing_err, overrun, parity_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int fall_cycle = 0;
  int rise_cycle = 0;
  logic rdy_prev = 1'b0;
  logic [DB-1:0] exp_q[$];

  // Reference model of the visible outputs, updated once per whole frame.
  logic [DB-1:0] m_data = '0;
  logic m_rdy = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

  uart_rx_sync #(.BAUD_DIV(BD), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .framing_err(framing_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic compareVal(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string name);
    compareVal({name, ".rx_data"}, int'(rx_data), int'(m_data));
    compareVal({name, ".rdy"}, int'(rdy), int'(m_rdy));
    compareVal({name, ".framing_err"}, int'(framing_err), int'(m_ferr));
    compareVal({name, ".overrun"}, int'(overrun), int'(m_ovr));
    compareVal({name, ".parity_err"}, int'(parity_err), int'(m_perr));
  endtask

  task automatic clearRdy();
    clr_rdy = 1'b1;
    waitCycles(1);
    clr_rdy = 1'b0;
    m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DB-1:0] data, input logic stop, input logic par_flip,
                               input int low_hold, input int gap);
    logic par_ok;
    logic expect_rise;
`ifdef UART_RX_PARITY_EN
    par_ok = !par_flip;
`else
    par_ok = 1'b1;
`endif
    expect_rise = stop && par_ok && !m_rdy;
    if (expect_rise) exp_q.push_back(data);
    fall_cycle = cycle;
    RX = 1'b0;
    waitCycles(BD);
    for (int i = 0; i < DB; i++) begin
      RX = data[i];
      waitCycles(BD);
    end
`ifdef UART_RX_PARITY_EN
    RX = (^data) ^ par_flip;
    waitCycles(BD);
`endif
    RX = stop;
    waitCycles(BD + (stop ? 0 : low_hold));
    RX = 1'b1;
    waitCycles(gap);
    if (!par_ok) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    else if (par_ok) begin
      if (m_rdy) m_ovr = 1'b1;
      m_rdy = 1'b1;
      m_data = data;
    end
    if (expect_rise) compareVal("latency", rise_cycle - fall_cycle, LAT);
  endtask

  // Scoreboard monitor: every rising rdy must deliver the oldest outstanding byte.
  initial begin
    logic [DB-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rdy && !rdy_prev) begin
        rise_cycle = cycle;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL mon_unexpected: got rdy with %0h, expected no byte", rx_data);
        end else begin
          e = exp_q.pop_front();
          compareVal("mon_data", int'(rx_data), int'(e));
        end
      end
      rdy_prev = rdy;
    end
  end

  initial begin
    logic [DB-1:0] d;
    logic s, pf;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("reset");

    applyStimulus(8'hA5, 1'b1, 1'b0, 0, 4);
    checkOutput("frame_a5");
    clearRdy();

    RX = 1'b0;
    waitCycles(4);
    RX = 1'b1;
    waitCycles(30);
    checkOutput("glitch");

    applyStimulus(8'h3C, 1'b0, 1'b0, 100, 4);
    checkOutput("framing");
    clearRdy();
    checkOutput("framing_clr");

    applyStimulus(8'h00, 1'b1, 1'b0, 0, 4);
    applyStimulus(8'hFF, 1'b1, 1'b0, 0, 4);
    checkOutput("overrun");
    clearRdy();
    checkOutput("overrun_clr");

    RX = 1'b0;
    waitCycles(BD);
    for (int i = 0; i < 3; i++) begin
      RX = i[0] ? 1'b0 : 1'b1;
      waitCycles(BD);
    end
    rst = 1'b1;
    RX = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    m_data = '0; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    checkOutput("rst_mid");
    waitCycles(5);
    applyStimulus(8'h81, 1'b1, 1'b0, 0, 4);
    checkOutput("after_rst");
    clearRdy();

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h03, 1'b1, 1'b1, 0, 4);
    checkOutput("parity_bad");
    clearRdy();
    applyStimulus(8'h03, 1'b1, 1'b0, 0, 4);
    checkOutput("parity_good");
    clearRdy();
`endif

    for (int n = 0; n < 20; n++) begin
      d  = DB'($urandom_range(0, 255));
      s  = ($urandom_range(0, 7) != 0);
      pf = ($urandom_range(0, 5) == 0);
      applyStimulus(d, s, pf, s ? 0 : $urandom_range(0, 20), $urandom_range(3, 10));
      checkOutput("random");
      if ($urandom_range(0, 3) != 0) clearRdy();
    end

    waitCycles(5);
    compareVal("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
